// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: operation codes and compare result values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // Operation select; one code per function, all 16 codes used.
    typedef enum logic [3:0] {
        ALU_ADD     = 4'b0000,
        ALU_SUB     = 4'b0001,
        ALU_MUL     = 4'b0010,
        ALU_DIV     = 4'b0011,
        ALU_AND     = 4'b0100,
        ALU_OR      = 4'b0101,
        ALU_NAND    = 4'b0110,
        ALU_NOR     = 4'b0111,
        ALU_XOR     = 4'b1000,
        ALU_XNOR    = 4'b1001,
        ALU_CMP_EQ  = 4'b1010,
        ALU_CMP_GT  = 4'b1011,
        ALU_CMP_LT  = 4'b1100,
        ALU_SHR     = 4'b1101,
        ALU_SHL     = 4'b1110,
        ALU_NOP     = 4'b1111
    } alu_op_e;

    // Each comparison reports a distinct non-zero code when true, so the
    // result alone identifies which comparison produced it.
    localparam int CMP_EQ_VAL = 1;
    localparam int CMP_GT_VAL = 2;
    localparam int CMP_LT_VAL = 3;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: computes the zero-extended OUT_WIDTH result of A op B.
// Latency: 0 cycles (pure logic, no state).
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   A, B     unsigned WIDTH-bit operands
//   ALU_FUN  4-bit operation select (alu_op_e codes)
//   RESULT   OUT_WIDTH-bit result; OUT_WIDTH must be 2*WIDTH to hold the full product
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 2 * WIDTH
) (
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           ALU_FUN,
    output logic [OUT_WIDTH-1:0] RESULT
);

    // Operands widened once so every arithmetic op is evaluated at full
    // result width (carry, borrow wrap and full product all come for free).
    logic [OUT_WIDTH-1:0] a_ext;
    logic [OUT_WIDTH-1:0] b_ext;

    // Bitwise results are formed at WIDTH bits before zero-extension so the
    // inverting ops cannot set any bit above WIDTH-1.
    logic [WIDTH-1:0] and_w;
    logic [WIDTH-1:0] or_w;
    logic [WIDTH-1:0] xor_w;
    logic [WIDTH-1:0] nand_w;
    logic [WIDTH-1:0] nor_w;
    logic [WIDTH-1:0] xnor_w;

    // Shifts are built at WIDTH+1 bits: SHL keeps the bit shifted out of A's
    // MSB at position WIDTH, SHR zero-fills from the top.
    logic [WIDTH:0] shl_w;
    logic [WIDTH:0] shr_w;

    logic b_is_zero;

    always_comb begin
        a_ext     = OUT_WIDTH'(A);
        b_ext     = OUT_WIDTH'(B);

        and_w     = A & B;
        or_w      = A | B;
        xor_w     = A ^ B;
        nand_w    = ~and_w;
        nor_w     = ~or_w;
        xnor_w    = ~xor_w;

        shl_w     = {A, 1'b0};
        shr_w     = {2'b00, A[WIDTH-1:1]};

        b_is_zero = (B == '0);
    end

    always_comb begin
        RESULT = '0;
        case (ALU_FUN)
            ALU_ADD:    RESULT = a_ext + b_ext;
            ALU_SUB:    RESULT = a_ext - b_ext;
            ALU_MUL:    RESULT = a_ext * b_ext;
            // Divide by zero is defined as 0 rather than left to the divider.
            ALU_DIV:    RESULT = b_is_zero ? '0 : (a_ext / b_ext);
            ALU_AND:    RESULT = OUT_WIDTH'(and_w);
            ALU_OR:     RESULT = OUT_WIDTH'(or_w);
            ALU_NAND:   RESULT = OUT_WIDTH'(nand_w);
            ALU_NOR:    RESULT = OUT_WIDTH'(nor_w);
            ALU_XOR:    RESULT = OUT_WIDTH'(xor_w);
            ALU_XNOR:   RESULT = OUT_WIDTH'(xnor_w);
            ALU_CMP_EQ: RESULT = (A == B) ? OUT_WIDTH'(CMP_EQ_VAL) : '0;
            ALU_CMP_GT: RESULT = (A >  B) ? OUT_WIDTH'(CMP_GT_VAL) : '0;
            ALU_CMP_LT: RESULT = (A <  B) ? OUT_WIDTH'(CMP_LT_VAL) : '0;
            ALU_SHR:    RESULT = OUT_WIDTH'(shr_w);
            ALU_SHL:    RESULT = OUT_WIDTH'(shl_w);
            ALU_NOP:    RESULT = '0;
            // Unknown select resolves to 0 instead of propagating garbage.
            default:    RESULT = '0;
        endcase
    end

endmodule

// File: rtl/alu_reg.sv
// Registered ALU: captures alu_comb's result into ALU_OUT on enabled rising edges.
// Latency: 1 cycle (inputs sampled at edge N appear on ALU_OUT just after edge N).
// Backpressure: none; EN=0 holds the last result, RST=1 clears it and overrides EN.
//
// Ports:
//   CLK      rising-edge clock
//   RST      synchronous active-high reset
//   A, B     unsigned WIDTH-bit operands
//   EN       result register load enable
//   ALU_FUN  4-bit operation select (alu_op_e codes)
//   ALU_OUT  OUT_WIDTH-bit registered result
module alu_reg
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 2 * WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 EN,
    input  logic [3:0]           ALU_FUN,
    output logic [OUT_WIDTH-1:0] ALU_OUT
);

    logic [OUT_WIDTH-1:0] alu_result;

    alu_comb #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_alu_comb (
        .A       (A),
        .B       (B),
        .ALU_FUN (ALU_FUN),
        .RESULT  (alu_result)
    );

    // ALU_OUT is the only state; reset wins over enable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ALU_OUT <= '0;
        end else if (EN) begin
            ALU_OUT <= alu_result;
        end
    end

endmodule

// File: tb/tb_alu_reg.sv
module tb_alu_reg;
    import alu_pkg::*;

    localparam int WIDTH     = 8;
    localparam int OUT_WIDTH = 2 * WIDTH;

    logic                 CLK;
    logic                 RST;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 EN;
    logic [3:0]           ALU_FUN;
    logic [OUT_WIDTH-1:0] ALU_OUT;

    int checks;
    int errors;

    alu_reg #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .A       (A),
        .B       (B),
        .EN      (EN),
        .ALU_FUN (ALU_FUN),
        .ALU_OUT (ALU_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [OUT_WIDTH-1:0] got,
                         input logic [OUT_WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, sample 1 time unit later.
    task automatic step(input logic rst, input logic en, input alu_op_e op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge CLK);
        RST     = rst;
        EN      = en;
        ALU_FUN = op;
        A       = a;
        B       = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_op(input string tag, input alu_op_e op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [OUT_WIDTH-1:0] exp);
        step(1'b0, 1'b1, op, a, b);
        check(tag, ALU_OUT, exp);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        RST     = 1'b1;
        EN      = 1'b1;
        A       = 8'hFF;
        B       = 8'hFF;
        ALU_FUN = ALU_MUL;

        // Reset held for two edges with a live MUL pending.
        step(1'b1, 1'b1, ALU_MUL, 8'hFF, 8'hFF);
        check("rst_edge1", ALU_OUT, 16'h0000);
        step(1'b1, 1'b1, ALU_MUL, 8'hFF, 8'hFF);
        check("rst_edge2", ALU_OUT, 16'h0000);
        run_op("mul_after_rst", ALU_MUL, 8'hFF, 8'hFF, 16'hFE01);

        // Arithmetic
        run_op("add_carry",   ALU_ADD, 8'd200, 8'd100, 16'h012C);
        run_op("add_max",     ALU_ADD, 8'hFF,  8'hFF,  16'h01FE);
        run_op("sub_wrap",    ALU_SUB, 8'd5,   8'd7,   16'hFFFE);
        run_op("sub_0_1",     ALU_SUB, 8'd0,   8'd1,   16'hFFFF);
        run_op("sub_pos",     ALU_SUB, 8'd7,   8'd5,   16'h0002);
        run_op("mul_small",   ALU_MUL, 8'd12,  8'd13,  16'd156);
        run_op("div",         ALU_DIV, 8'd100, 8'd7,   16'd14);
        run_op("div_by_zero", ALU_DIV, 8'd9,   8'd0,   16'h0000);

        // Bitwise, inverting ops confined to the low WIDTH bits
        run_op("and",  ALU_AND,  8'hF0, 8'h3C, 16'h0030);
        run_op("or",   ALU_OR,   8'hF0, 8'h3C, 16'h00FC);
        run_op("nand", ALU_NAND, 8'hF0, 8'h3C, 16'h00CF);
        run_op("nor",  ALU_NOR,  8'hF0, 8'h3C, 16'h0003);
        run_op("xor",  ALU_XOR,  8'hF0, 8'h3C, 16'h00CC);
        run_op("xnor", ALU_XNOR, 8'hF0, 8'h3C, 16'h0033);

        // Compares
        run_op("eq_true",  ALU_CMP_EQ, 8'h55, 8'h55, 16'd1);
        run_op("gt_equal", ALU_CMP_GT, 8'h55, 8'h55, 16'd0);
        run_op("gt_true",  ALU_CMP_GT, 8'd9,  8'd3,  16'd2);
        run_op("lt_true",  ALU_CMP_LT, 8'd3,  8'd9,  16'd3);
        run_op("eq_false", ALU_CMP_EQ, 8'd3,  8'd9,  16'd0);
        run_op("lt_false", ALU_CMP_LT, 8'd9,  8'd3,  16'd0);

        // Shifts and NOP
        run_op("shr", ALU_SHR, 8'h81, 8'h00, 16'h0040);
        run_op("shl", ALU_SHL, 8'h81, 8'h00, 16'h0102);
        run_op("nop", ALU_NOP, 8'h81, 8'h42, 16'h0000);

        // Hold with EN=0 while inputs change
        run_op("hold_load", ALU_ADD, 8'd1, 8'd2, 16'd3);
        step(1'b0, 1'b0, ALU_MUL, 8'hFF, 8'hFF);
        check("hold_1", ALU_OUT, 16'd3);
        step(1'b0, 1'b0, ALU_SUB, 8'd0,  8'd1);
        check("hold_2", ALU_OUT, 16'd3);
        step(1'b0, 1'b0, ALU_OR,  8'hAA, 8'h55);
        check("hold_3", ALU_OUT, 16'd3);

        // Reset with EN=0 still clears
        step(1'b1, 1'b0, ALU_ADD, 8'd1, 8'd2);
        check("rst_no_en", ALU_OUT, 16'h0000);

        // Mid-stream reset with EN=1 overrides the pending op
        run_op("pre_rst", ALU_ADD, 8'd10, 8'd20, 16'd30);
        step(1'b1, 1'b1, ALU_MUL, 8'hFF, 8'hFF);
        check("rst_over_en", ALU_OUT, 16'h0000);
        run_op("fresh_after_rst", ALU_XOR, 8'hFF, 8'h0F, 16'h00F0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
